// File: rtl/prm_sweep_pkg.sv
// Shared types and default widths for the PRM edge sweep collector.
// Optional blocked-edge counter is enabled with PRM_SWEEP_POPCNT_EN.
package prm_sweep_pkg;

   localparam int DEF_CODE_W = 15;
   localparam int DEF_WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      FLUSH,
      FIN
   } sweep_state_t;

   // Layout of one emitted bitmap word at the default widths
   typedef struct packed {
      logic [DEF_WORD_W-1:0] data;
      logic [DEF_CODE_W-1:0] base;
      logic                  last;
   } bm_word_t;

endpackage

// File: rtl/prm_sweep_packer.sv
// Packs per-code mask bits into bitmap words and holds one finished word
// in a valid/ready output register, raising stall when a word cannot close.
module prm_sweep_packer #(
   parameter int CODE_W = 15,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              active,
   input  logic              s_mask,
   input  logic              s_last,
   input  logic [CODE_W-1:0] s_code,
   output logic              take,
   output logic              stall,
   input  logic              bm_ready,
   output logic              bm_valid,
   output logic [WORD_W-1:0] bm_data,
   output logic [CODE_W-1:0] bm_base,
   output logic              bm_last
);

   localparam int IDX_W = $clog2(WORD_W);

   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] pack;
   logic [CODE_W-1:0] base_q;
   logic              close;
   logic              accept;
   logic [WORD_W-1:0] word_next;
   logic [CODE_W-1:0] word_base;

   // A word closes on its last slot or on the final code of the sweep; it can
   // only close if the output register is empty or draining this same cycle.
   assign close     = s_last || (idx == IDX_W'(WORD_W - 1));
   assign accept    = bm_valid && bm_ready;
   assign stall     = active && close && bm_valid && !bm_ready;
   assign take      = active && !stall;
   assign word_next = pack | (WORD_W'(s_mask) << idx);
   assign word_base = (idx == '0) ? s_code : base_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         pack     <= '0;
         base_q   <= '0;
         bm_valid <= 1'b0;
         bm_data  <= '0;
         bm_base  <= '0;
         bm_last  <= 1'b0;
      end else begin
         if (accept) begin
            bm_valid <= 1'b0;
         end
         if (take) begin
            if (close) begin
               bm_valid <= 1'b1;
               bm_data  <= word_next;
               bm_base  <= word_base;
               bm_last  <= s_last;
               pack     <= '0;
               idx      <= '0;
            end else begin
               pack <= word_next;
               idx  <= idx + 1'b1;
               if (idx == '0) begin
                  base_q <= s_code;
               end
            end
         end
      end
   end

endmodule

// File: rtl/prm_edge_sweep_collector.sv
// Sweeps edge codes lo..hi through an external combinational obstacle checker
// and streams blocked-edge bitmaps. Define PRM_SWEEP_POPCNT_EN for blocked_cnt.
module prm_edge_sweep_collector
   import prm_sweep_pkg::*;
#(
   parameter int CODE_W = DEF_CODE_W,
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CODE_W-1:0] lo,
   input  logic [CODE_W-1:0] hi,
   output logic              busy,
   output logic              done,
   output logic              range_err,
   output logic [CODE_W-1:0] chk_code,
   input  logic              chk_mask,
`ifdef PRM_SWEEP_POPCNT_EN
   output logic [CODE_W:0]   blocked_cnt,
`endif
   output logic              bm_valid,
   input  logic              bm_ready,
   output logic [WORD_W-1:0] bm_data,
   output logic [CODE_W-1:0] bm_base,
   output logic              bm_last
);

   sweep_state_t      state;
   logic [CODE_W:0]   cur;
   logic [CODE_W-1:0] hi_q;
   logic              scan;
   logic              s_last;
   logic              take;
   logic              stall;

   // The extra counter bit lets hi at the top of the code space finish cleanly
   assign scan   = (state == SCAN);
   assign s_last = (cur == {1'b0, hi_q});

   prm_sweep_packer #(
      .CODE_W(CODE_W),
      .WORD_W(WORD_W)
   ) u_packer (
      .clk      (clk),
      .rst_n    (rst_n),
      .active   (scan),
      .s_mask   (chk_mask),
      .s_last   (s_last),
      .s_code   (chk_code),
      .take     (take),
      .stall    (stall),
      .bm_ready (bm_ready),
      .bm_valid (bm_valid),
      .bm_data  (bm_data),
      .bm_base  (bm_base),
      .bm_last  (bm_last)
   );

   // chk_code stops on hi rather than following cur past it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur       <= '0;
         hi_q      <= '0;
         chk_code  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         range_err <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  range_err <= 1'b0;
                  hi_q      <= hi;
                  cur       <= {1'b0, lo};
                  chk_code  <= lo;
                  if (lo > hi) begin
                     range_err <= 1'b1;
                     done      <= 1'b1;
                     state     <= FIN;
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (take) begin
                  cur <= cur + 1'b1;
                  if (s_last) begin
                     state <= FLUSH;
                  end else begin
                     chk_code <= chk_code + 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (!bm_valid || bm_ready) begin
                  done  <= 1'b1;
                  state <= FIN;
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PRM_SWEEP_POPCNT_EN
   // Counts mask bits actually consumed, so stalled cycles are not recounted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blocked_cnt <= '0;
      end else if (state == IDLE && start) begin
         blocked_cnt <= '0;
      end else if (take && chk_mask) begin
         blocked_cnt <= blocked_cnt + 1'b1;
      end
   end
`endif

   logic unused_stall;
   assign unused_stall = stall;

endmodule

// File: tb/tb_prm_edge_sweep_collector.sv
// Scoreboard bench for prm_edge_sweep_collector with a behavioural checker model.
// Exercises blocked_cnt when PRM_SWEEP_POPCNT_EN is defined.
module tb_prm_edge_sweep_collector;
   import prm_sweep_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [14:0] lo;
   logic [14:0] hi;
   logic        busy;
   logic        done;
   logic        range_err;
   logic [14:0] chk_code;
   logic        chk_mask;
   logic        bm_valid;
   logic        bm_ready;
   logic [31:0] bm_data;
   logic [14:0] bm_base;
   logic        bm_last;
`ifdef PRM_SWEEP_POPCNT_EN
   logic [15:0] blocked_cnt;
`endif

   int       vectors    = 0;
   int       miscompares = 0;
   int       done_cnt   = 0;
   int       exp_done   = 0;
   logic [1:0] mode     = 2'd0;
   bm_word_t exp_q[$];

   always #5 clk = ~clk;

   prm_edge_sweep_collector dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .lo          (lo),
      .hi          (hi),
      .busy        (busy),
      .done        (done),
      .range_err   (range_err),
      .chk_code    (chk_code),
      .chk_mask    (chk_mask),
`ifdef PRM_SWEEP_POPCNT_EN
      .blocked_cnt (blocked_cnt),
`endif
      .bm_valid    (bm_valid),
      .bm_ready    (bm_ready),
      .bm_data     (bm_data),
      .bm_base     (bm_base),
      .bm_last     (bm_last)
   );

   // Behavioural obstacle checker: mode 0 odd codes, 1 everything, 2 code%4==3
   always_comb begin
      chk_mask = 1'b0;
      case (mode)
         2'd0:    chk_mask = chk_code[0];
         2'd1:    chk_mask = 1'b1;
         2'd2:    chk_mask = chk_code[0] & chk_code[1];
         default: chk_mask = 1'b0;
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pushWord(input logic [31:0] data, input logic [14:0] base,
                           input logic last);
      bm_word_t w;
      w.data = data;
      w.base = base;
      w.last = last;
      exp_q.push_back(w);
   endtask

   task automatic applyStimulus(input logic [14:0] l, input logic [14:0] h);
      @(posedge clk);
      #1;
      lo    = l;
      hi    = h;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lo    = 15'h5555;
      hi    = 15'h0000;
   endtask

   task automatic waitDone(input string name, input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, {31'd0, done}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every handshake seen at the falling edge is one accepted word
   always @(negedge clk) begin
      if (rst_n && bm_valid && bm_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_word", bm_data, 32'hDEAD_BEEF);
         end else begin
            bm_word_t e;
            e = exp_q.pop_front();
            checkOutput("bm_data", bm_data, e.data);
            checkOutput("bm_base", {17'd0, bm_base}, {17'd0, e.base});
            checkOutput("bm_last", {31'd0, bm_last}, {31'd0, e.last});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done) done_cnt++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat;
      rst_n    = 1'b0;
      start    = 1'b0;
      lo       = '0;
      hi       = '0;
      bm_ready = 1'b1;
      #23;
      checkOutput("reset_outputs",
                  {busy, done, range_err, bm_valid, bm_last, chk_code, bm_base},
                  32'd0);
      checkOutput("reset_data", bm_data, 32'd0);
      rst_n = 1'b1;

      // Two full words of alternating mask, first-word latency measured
      $display("[TB] sweep 0x0000..0x003F, odd codes blocked");
      mode = 2'd0;
      pushWord(32'hAAAA_AAAA, 15'h0000, 1'b0);
      pushWord(32'hAAAA_AAAA, 15'h0020, 1'b1);
      applyStimulus(15'h0000, 15'h003F);
      checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
      lat = 0;
      while (!bm_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      // valid follows the 32nd sampling edge after the start-sampling edge
      checkOutput("first_word_latency", lat, 32'd32);
      waitDone("done_sweep1", 200);
      exp_done++;
      checkOutput("done_count1", done_cnt, exp_done);
      checkOutput("queue_empty1", exp_q.size(), 32'd0);
      checkOutput("busy_idle1", {31'd0, busy}, 32'd0);

      // Top of the code space: partial word, no wrap
      $display("[TB] sweep 0x7FF0..0x7FFF, all blocked");
      mode = 2'd1;
      pushWord(32'h0000_FFFF, 15'h7FF0, 1'b1);
      applyStimulus(15'h7FF0, 15'h7FFF);
      waitDone("done_sweep2", 100);
      exp_done++;
      checkOutput("done_count2", done_cnt, exp_done);
      checkOutput("queue_empty2", exp_q.size(), 32'd0);
      checkOutput("chk_code_no_wrap", {17'd0, chk_code}, 32'h0000_7FFF);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("stay_idle2", {30'd0, busy, bm_valid}, 32'd0);

      // Reversed range
      $display("[TB] reversed range 0x0010..0x000F");
      applyStimulus(15'h0010, 15'h000F);
      waitDone("done_range_err", 20);
      exp_done++;
      checkOutput("done_count3", done_cnt, exp_done);
      checkOutput("range_err_set", {31'd0, range_err}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("range_err_held", {30'd0, range_err, busy}, 32'd2);

      // Consumer stall with four words outstanding
      $display("[TB] sweep 0x0000..0x007F with consumer stalled");
      mode     = 2'd0;
      bm_ready = 1'b0;
      pushWord(32'hAAAA_AAAA, 15'h0000, 1'b0);
      pushWord(32'hAAAA_AAAA, 15'h0020, 1'b0);
      pushWord(32'hAAAA_AAAA, 15'h0040, 1'b0);
      pushWord(32'hAAAA_AAAA, 15'h0060, 1'b1);
      applyStimulus(15'h0000, 15'h007F);
      checkOutput("range_err_clear", {31'd0, range_err}, 32'd0);
      repeat (80) @(posedge clk);
      #1;
      checkOutput("stall_code", {17'd0, chk_code}, 32'h0000_003F);
      checkOutput("stall_data", bm_data, 32'hAAAA_AAAA);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("stall_code_frozen", {17'd0, chk_code}, 32'h0000_003F);
      checkOutput("stall_hold", {bm_valid, bm_data[30:0]}, 32'hAAAA_AAAA);
      checkOutput("stall_base", {17'd0, bm_base}, 32'd0);
      bm_ready = 1'b1;
      waitDone("done_stall", 300);
      exp_done++;
      checkOutput("done_count4", done_cnt, exp_done);
      checkOutput("queue_empty4", exp_q.size(), 32'd0);

      // Reset in the middle of a sweep with a word pending
      $display("[TB] asynchronous reset during sweep");
      bm_ready = 1'b0;
      applyStimulus(15'h0000, 15'h003F);
      repeat (40) @(posedge clk);
      #1;
      checkOutput("pre_reset_valid", {31'd0, bm_valid}, 32'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_mid_valid", {31'd0, bm_valid}, 32'd0);
      checkOutput("reset_mid_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      bm_ready = 1'b1;
      pushWord(32'hAAAA_AAAA, 15'h0000, 1'b0);
      pushWord(32'hAAAA_AAAA, 15'h0020, 1'b1);
      applyStimulus(15'h0000, 15'h003F);
      waitDone("done_after_reset", 200);
      exp_done++;
      checkOutput("done_count5", done_cnt, exp_done);
      checkOutput("queue_empty5", exp_q.size(), 32'd0);

      // Sparse mask across eight words
      $display("[TB] sweep 0x0000..0x00FF, code%%4==3 blocked");
      mode = 2'd2;
      for (int k = 0; k < 8; k++) begin
         pushWord(32'h8888_8888, 15'(k * 32), (k == 7));
      end
      applyStimulus(15'h0000, 15'h00FF);
      waitDone("done_sweep6", 400);
      exp_done++;
      checkOutput("done_count6", done_cnt, exp_done);
      checkOutput("queue_empty6", exp_q.size(), 32'd0);
`ifdef PRM_SWEEP_POPCNT_EN
      checkOutput("blocked_cnt", {16'd0, blocked_cnt}, 32'd64);
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prm_edge_sweep_collector.md
Name: prm_edge_sweep_collector

Overview:
- Sequential sweep engine for the PRM obstacle-check fabric.
- Sits directly around one combinational prm_oblgc_chk* instance.
- Upstream side: generates every 15-bit edge code in a requested range onto the checker's A..O inputs.
- Downstream side: consumes the checker's edge_mask result and packs results into 32-bit blocked-edge bitmap words, streamed out with valid/ready to the roadmap builder.

Parameters:
- CODE_W, 15, edge-code width; must match checker input count (A=bit0 ... O=bit14).
- WORD_W, 32, bitmap word width; power of two, 8..64.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches lo/hi; honoured only in IDLE.
- lo  in  CODE_W  first code of range, inclusive.
- hi  in  CODE_W  last code of range, inclusive.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse at sweep end.
- range_err  out  1  held high from done until next accepted start when lo>hi.
- chk_code  out  CODE_W  registered code driven to checker inputs.
- chk_mask  in  1  checker edge_mask, combinational from chk_code.
- bm_valid  out  1  bitmap word available.
- bm_ready  in  1  consumer accepts word when bm_valid&bm_ready.
- bm_data  out  WORD_W  bit i = mask of code bm_base+i; unused bits 0.
- bm_base  out  CODE_W  code of bit 0.
- bm_last  out  1  final word of sweep.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- States: IDLE, SCAN, FLUSH, FIN.
- IDLE + start: latch lo/hi.
  - lo<=hi: go to SCAN with chk_code=lo.
  - lo>hi: go to FIN with range_err=1; no words emitted.
- SCAN:
  - Each cycle not stalled, sample chk_mask into pack bit (cur-base) and advance chk_code by 1.
  - Use a CODE_W+1-bit counter so hi=0x7FFF terminates without wrap.
  - Checker path: one cycle, register to register; no pipeline delay.
- Word close: pack buffer hands a word to the output register when WORD_W bits are filled or the code equals hi.
  - A partial final word is zero-padded, with bm_last=1.
- Output register: single entry.
  - Holds bm_data/bm_base/bm_last stable while bm_valid&!bm_ready.
- Stall: if a word must close while the output register is still full and not being accepted, SCAN freezes; chk_code and pack buffer hold.
  - Simultaneous accept and close in the same cycle: no stall; new word loaded.
- After sampling hi, go to FLUSH. FLUSH waits for the final word to be accepted, then goes to FIN.
- FIN: done=1 for one cycle, busy drops, return to IDLE.
- Latency: first word valid WORD_W+1 cycles after start for a full word with no stall.
- start while busy: ignored. lo/hi changes after start: ignored.
- Asynchronous reset mid-sweep: immediately IDLE; pending word discarded; bm_valid=0.

Optional Feature:
- Macro: PRM_SWEEP_POPCNT_EN.
- Defined:
  - Adds output blocked_cnt [CODE_W:0], the count of chk_mask=1 over the sweep.
  - Cleared on accepted start; final value stable from done until next start.
  - Saturation is not needed: maximum is 32768.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package prm_sweep_pkg:
  - CODE_W, WORD_W defaults.
  - sweep_state_t enum (IDLE, SCAN, FLUSH, FIN).
  - Bitmap word struct {data, base, last}.
- Sub-module prm_sweep_packer: shift/index pack buffer plus single-entry output register with valid/ready and stall output.
- The top holds the FSM and code counter.

Test Plan:
- lo=0x0000, hi=0x003F, checker model = code[0], bm_ready=1 → two words 0xAAAAAAAA at bases 0x0000 and 0x0020; second has bm_last=1; done once.
- lo=0x7FF0, hi=0x7FFF, all-ones mask → one word 0x0000FFFF, bm_last=1; sweep terminates with no wrap to 0x0000.
- lo=0x0010, hi=0x000F → no bm_valid; done pulses; range_err=1.
- Hold bm_ready=0 for 40 cycles mid-sweep of 0..0x7F → chk_code frozen; bm_data stable; after release, four words in order, none lost.
- Assert rst_n=0 during SCAN → bm_valid and busy 0 same cycle; a new start after reset sweeps normally.
- With PRM_SWEEP_POPCNT_EN, sweep 0..0x00FF with mask=code[0]&code[1] → blocked_cnt=64 at done.
